// File: rtl/spectrum_analyzer_core.sv
// spectrum_analyzer_core: AXI4-Lite sample buffer, sequential 8-point DFT power engine
// and peak-bin LED driver for the Zedboard spectrum analyzer.
module spectrum_analyzer_core #(
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int N_POINTS = 8
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic [3:0]                      led
);
    typedef enum logic [1:0] {IDLE, ACCUM, POWER, DONE_ST} state_t;
    localparam logic signed [15:0] COS_ROM [8] = '{16'sd16384, 16'sd11585, 16'sd0, -16'sd11585,
                                                  -16'sd16384, -16'sd11585, 16'sd0, 16'sd11585};
    localparam logic signed [15:0] SIN_ROM [8] = '{16'sd0, 16'sd11585, 16'sd16384, 16'sd11585,
                                                  16'sd0, -16'sd11585, -16'sd16384, -16'sd11585};
    state_t state, state_nxt;
    logic signed [15:0] x [N_POINTS];
    logic [31:0] power [N_POINTS];
    logic [2:0] wptr, k, n, m, peak_bin;
    logic [3:0] sample_cnt, waddr, raddr;
    logic [31:0] peak_val, p_sat, rd_mux;
    logic signed [35:0] acc_re, acc_im, x_ext, c_ext, s_ext, prod_re, prod_im;
    logic signed [43:0] re, im;
    logic [43:0] p;
    logic done, busy, wr_en, rd_en, start, clear, aw_go, unused_ok;
    assign waddr = s_axi_awaddr[5:2];
    assign raddr = s_axi_araddr[5:2];
    assign wr_en = s_axi_awready & s_axi_awvalid & s_axi_wvalid;
    assign rd_en = s_axi_arready & s_axi_arvalid;
    assign busy = state == ACCUM || state == POWER;
    assign clear = wr_en && waddr == 4'd0 && s_axi_wdata[1];
    assign start = wr_en && waddr == 4'd0 && s_axi_wdata[0] && !busy;
    assign aw_go = s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid && !s_axi_awready;
    assign m = k * n;
    assign x_ext = {{20{x[n][15]}}, x[n]};
    assign c_ext = {{20{COS_ROM[m][15]}}, COS_ROM[m]};
    assign s_ext = {{20{SIN_ROM[m][15]}}, SIN_ROM[m]};
    assign prod_re = x_ext * c_ext;
    assign prod_im = x_ext * s_ext;
    assign re = $signed({{8{acc_re[35]}}, acc_re}) >>> 14;
    assign im = $signed({{8{acc_im[35]}}, acc_im}) >>> 14;
    assign p = re * re + im * im;
    assign p_sat = |p[43:32] ? 32'hFFFF_FFFF : p[31:0];
    assign rd_mux = raddr == 4'd1 ? {25'd0, peak_bin, 2'd0, done, busy} :
                    raddr == 4'd3 ? {28'd0, sample_cnt} :
                    (raddr >= 4'd4 && raddr <= 4'd11) ? power[raddr[2:0] + 3'd4] : 32'd0;
    assign s_axi_bresp = 2'b00;
    assign s_axi_rresp = 2'b00;
    assign led = {peak_bin, done};
    assign unused_ok = &{1'b0, s_axi_wstrb, s_axi_wdata[31:16], s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s_axi_awready <= 1'b0;
            s_axi_wready <= 1'b0;
            s_axi_bvalid <= 1'b0;
            s_axi_arready <= 1'b0;
            s_axi_rvalid <= 1'b0;
            s_axi_rdata <= '0;
        end else begin
            s_axi_awready <= aw_go;
            s_axi_wready <= aw_go;
            s_axi_bvalid <= wr_en ? 1'b1 : s_axi_bready ? 1'b0 : s_axi_bvalid;
            s_axi_arready <= s_axi_arvalid && !s_axi_rvalid && !s_axi_arready;
            s_axi_rvalid <= rd_en ? 1'b1 : s_axi_rready ? 1'b0 : s_axi_rvalid;
            if (rd_en) s_axi_rdata <= rd_mux;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else state <= state_nxt;
    end

    // CLEAR overrides everything, including a START in the same write
    always_comb begin
        state_nxt = clear ? IDLE :
                    state == ACCUM ? (n == 3'd7 ? POWER : ACCUM) :
                    state == POWER ? (k == 3'd7 ? DONE_ST : ACCUM) :
                    start ? ACCUM : IDLE;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < N_POINTS; i++) begin
                x[i] <= '0;
                power[i] <= '0;
            end
            wptr <= '0;
            sample_cnt <= '0;
            k <= '0;
            n <= '0;
            acc_re <= '0;
            acc_im <= '0;
            peak_val <= '0;
            peak_bin <= '0;
            done <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < N_POINTS; i++) begin
                x[i] <= '0;
                power[i] <= '0;
            end
            wptr <= '0;
            sample_cnt <= '0;
            k <= '0;
            n <= '0;
            acc_re <= '0;
            acc_im <= '0;
            peak_val <= '0;
            peak_bin <= '0;
            done <= 1'b0;
        end else begin
            if (wr_en && waddr == 4'd2 && !busy) begin
                x[wptr] <= s_axi_wdata[15:0];
                wptr <= wptr + 3'd1;
                sample_cnt <= sample_cnt == 4'd8 ? 4'd8 : sample_cnt + 4'd1;
            end
            if (start) begin
                done <= 1'b0;
                k <= '0;
                n <= '0;
                acc_re <= '0;
                acc_im <= '0;
                peak_val <= '0;
                peak_bin <= '0;
            end
            if (state == ACCUM) begin
                acc_re <= acc_re + prod_re;
                acc_im <= acc_im - prod_im;
                n <= n + 3'd1;
            end
            if (state == POWER) begin
                power[k] <= p_sat;
                if (p_sat > peak_val) begin
                    peak_val <= p_sat;
                    peak_bin <= k;
                end
                acc_re <= '0;
                acc_im <= '0;
                k <= k + 3'd1;
                if (k == 3'd7) done <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_spectrum_analyzer_core.sv
// tb_spectrum_analyzer_core: table vectors, hand-written corner sequences and random
// trials against an arithmetic DFT reference model.
module tb_spectrum_analyzer_core;
    logic aclk = 1'b0, aresetn = 1'b0;
    logic [5:0] awaddr = '0, araddr = '0;
    logic awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0] wstrb = 4'hF;
    logic awready, wready, bvalid, arready, rvalid;
    logic [1:0] bresp, rresp;
    logic [31:0] rdata;
    logic [3:0] led;

    spectrum_analyzer_core dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .led(led)
    );

    always #5 aclk = ~aclk;
    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    int total = 0, passed = 0, wr_cyc = 0;
    longint cs [8] = '{16384, 11585, 0, -11585, -16384, -11585, 0, 11585};
    longint sn [8] = '{0, 11585, 16384, 11585, 0, -11585, -16384, -11585};
    longint mx [8];
    logic [31:0] mp [8];
    int mpeak = 0, mwptr = 0, mcnt = 0;

    typedef struct packed {
        logic [127:0] smp;
        logic [255:0] pw;
        logic [2:0]   peak;
        logic         poke;
    } vec_t;
    vec_t vt [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d);
        int t;
        @(negedge aclk);
        awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        t = 0;
        while (!(awready && wready) && t < 20) begin @(negedge aclk); t++; end
        chk("aw/w ready", {30'd0, awready, wready}, 32'd3);
        @(negedge aclk);
        wr_cyc = cyc; awvalid = 1'b0; wvalid = 1'b0;
        t = 0;
        while (!bvalid && t < 20) begin @(negedge aclk); t++; end
        chk("bvalid", {31'd0, bvalid}, 32'd1);
        chk("bresp", {30'd0, bresp}, 32'd0);
        @(negedge aclk);
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [5:0] a, output logic [31:0] d);
        int t;
        @(negedge aclk);
        araddr = a; arvalid = 1'b1; rready = 1'b0;
        t = 0;
        while (!arready && t < 20) begin @(negedge aclk); t++; end
        chk("arready", {31'd0, arready}, 32'd1);
        @(negedge aclk);
        arvalid = 1'b0;
        t = 0;
        while (!rvalid && t < 20) begin @(negedge aclk); t++; end
        chk("rvalid", {31'd0, rvalid}, 32'd1);
        chk("rresp", {30'd0, rresp}, 32'd0);
        d = rdata; rready = 1'b1;
        @(negedge aclk);
        rready = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [5:0] a, input logic [31:0] exp);
        logic [31:0] d;
        axi_read(a, d);
        chk(name, d, exp);
    endtask

    task automatic put_sample(input logic [15:0] v);
        axi_write(6'h08, {16'h0, v});
        mx[mwptr] = longint'($signed(v));
        mwptr = (mwptr + 1) % 8;
        if (mcnt < 8) mcnt++;
    endtask

    task automatic do_clear();
        axi_write(6'h00, 32'd2);
        mwptr = 0;
        mcnt = 0;
    endtask

    task automatic wait_done(input int st, output int cy);
        int t;
        t = 0;
        while (!led[0] && t < 300) begin @(negedge aclk); t++; end
        chk("done rises", {31'd0, led[0]}, 32'd1);
        cy = cyc - st;
    endtask

    function automatic void compute_model();
        longint re, im, p;
        logic [31:0] best;
        best = 0;
        mpeak = 0;
        for (int k = 0; k < 8; k++) begin
            re = 0;
            im = 0;
            for (int n = 0; n < 8; n++) begin
                re += mx[n] * cs[(k * n) % 8];
                im -= mx[n] * sn[(k * n) % 8];
            end
            re = re >>> 14;
            im = im >>> 14;
            p = re * re + im * im;
            mp[k] = (p > 64'sd4294967295) ? 32'hFFFF_FFFF : 32'(p);
            if (mp[k] > best) begin best = mp[k]; mpeak = k; end
        end
    endfunction

    task automatic check_results(input string tag);
        logic [31:0] d;
        for (int k = 0; k < 8; k++) begin
            axi_read(6'(16 + 4 * k), d);
            chk($sformatf("%s POWER[%0d]", tag, k), d, mp[k]);
        end
        rd_chk({tag, " STATUS"}, 6'h04, {25'd0, 3'(mpeak), 2'b00, 2'b10});
        chk({tag, " led"}, {28'd0, led}, {28'd0, 3'(mpeak), 1'b1});
        rd_chk({tag, " SAMPLE_CNT"}, 6'h0C, 32'(mcnt));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int st, cy;
        logic [31:0] d;
        vt[0] = '{smp: {{7{16'd0}}, 16'd1000}, pw: {8{32'h000F4240}}, peak: 3'd0, poke: 1'b0};
        vt[1] = '{smp: {8{16'd1000}}, pw: {{7{32'h0}}, 32'h03D09000}, peak: 3'd0, poke: 1'b0};
        vt[2] = '{smp: {2{16'h0000, 16'hFC18, 16'h0000, 16'h03E8}},
                  pw: {32'h0, 32'h00F42400, 32'h0, 32'h0, 32'h0, 32'h00F42400, 32'h0, 32'h0},
                  peak: 3'd2, poke: 1'b0};
        vt[3] = '{smp: {8{16'h7FFF}}, pw: {{7{32'h0}}, 32'hFFFF_FFFF}, peak: 3'd0, poke: 1'b1};
        for (int i = 0; i < 8; i++) mx[i] = 0;

        // reset: no handshake signal may answer requests held high during reset
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            chk("reset handshakes", {27'd0, awready, wready, bvalid, arready, rvalid}, 32'd0);
            chk("reset led", {28'd0, led}, 32'd0);
        end
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        rd_chk("CTRL reads 0", 6'h00, 32'd0);
        rd_chk("STATUS after reset", 6'h04, 32'd0);
        rd_chk("SAMPLE_CNT after reset", 6'h0C, 32'd0);
        for (int k = 0; k < 8; k++) rd_chk($sformatf("POWER[%0d] after reset", k), 6'(16 + 4 * k), 32'd0);
        rd_chk("unmapped read", 6'h3C, 32'd0);
        axi_write(6'h04, 32'hFFFF_FFFF);
        axi_write(6'h3C, 32'hFFFF_FFFF);
        rd_chk("STATUS after ignored writes", 6'h04, 32'd0);
        rd_chk("SAMPLE_CNT after ignored writes", 6'h0C, 32'd0);

        foreach (vt[i]) begin
            do_clear();
            for (int s = 0; s < 8; s++) put_sample(vt[i].smp[16 * s +: 16]);
            axi_write(6'h00, 32'd1);
            st = wr_cyc;
            if (vt[i].poke) begin
                axi_write(6'h00, 32'd1);
                axi_write(6'h08, 32'd5);
                rd_chk($sformatf("vec%0d cnt while busy", i), 6'h0C, 32'd8);
                axi_read(6'h04, d);
                chk($sformatf("vec%0d busy bit", i), {31'd0, d[0]}, 32'd1);
            end
            wait_done(st, cy);
            chk($sformatf("vec%0d busy cycles", i), 32'(cy), 32'd72);
            for (int k = 0; k < 8; k++)
                rd_chk($sformatf("vec%0d POWER[%0d]", i, k), 6'(16 + 4 * k), vt[i].pw[32 * k +: 32]);
            rd_chk($sformatf("vec%0d STATUS", i), 6'h04, {25'd0, vt[i].peak, 2'b00, 2'b10});
            chk($sformatf("vec%0d led", i), {28'd0, led}, {28'd0, vt[i].peak, 1'b1});
        end

        // abort by CLEAR about 20 cycles into a computation, then 9 writes wrap onto x0
        axi_write(6'h00, 32'd1);
        st = wr_cyc;
        while (cyc < st + 18) @(negedge aclk);
        do_clear();
        chk("clear abort led", {28'd0, led}, 32'd0);
        rd_chk("clear abort STATUS", 6'h04, 32'd0);
        for (int k = 0; k < 8; k++) rd_chk($sformatf("clear abort POWER[%0d]", k), 6'(16 + 4 * k), 32'd0);
        rd_chk("clear abort SAMPLE_CNT", 6'h0C, 32'd0);
        for (int s = 0; s < 9; s++) put_sample(16'($urandom));
        rd_chk("SAMPLE_CNT saturates", 6'h0C, 32'd8);
        axi_write(6'h00, 32'd1);
        st = wr_cyc;
        wait_done(st, cy);
        chk("wrap busy cycles", 32'(cy), 32'd72);
        compute_model();
        check_results("wrap");

        for (int tr = 0; tr < 8; tr++) begin
            int nwr;
            logic [15:0] v;
            if (tr == 0 || $urandom_range(0, 1) == 1) begin
                do_clear();
                nwr = $urandom_range(8, 11);
            end else nwr = $urandom_range(1, 5);
            for (int s = 0; s < nwr; s++) begin
                case ($urandom_range(0, 3))
                    0: v = $urandom_range(0, 1) ? 16'h7FFF : 16'h8000;
                    1: v = 16'($signed(11'($urandom)));
                    default: v = 16'($urandom);
                endcase
                put_sample(v);
            end
            axi_write(6'h00, (tr % 3 == 0) ? 32'hFFFF_FFFD : 32'd1);
            st = wr_cyc;
            wait_done(st, cy);
            chk($sformatf("rand%0d busy cycles", tr), 32'(cy), 32'd72);
            compute_model();
            check_results($sformatf("rand%0d", tr));
        end

        // reset in the middle of a computation
        axi_write(6'h00, 32'd1);
        repeat (10) @(negedge aclk);
        aresetn = 1'b0;
        @(negedge aclk);
        chk("mid reset led", {28'd0, led}, 32'd0);
        aresetn = 1'b1;
        mwptr = 0;
        mcnt = 0;
        rd_chk("mid reset STATUS", 6'h04, 32'd0);
        rd_chk("mid reset SAMPLE_CNT", 6'h0C, 32'd0);
        rd_chk("mid reset POWER[0]", 6'h10, 32'd0);
        repeat (80) @(negedge aclk);
        chk("mid reset stays idle", {28'd0, led}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/spectrum_analyzer_core.md
Name: spectrum_analyzer_core

Overview:
- Programmable-logic core of the Zedboard spectrum analyzer.
- The Zynq PS GP master loads 8 signed 16-bit samples over AXI4-Lite and starts a sequential 8-point DFT.
- The core computes per-bin power and the peak bin, and drives the 4 board LEDs.
- Sits behind the PS7 AXI interconnect in the board top; clocked by PS FCLK0 and reset by the PS reset.

Parameters:
- C_S_AXI_ADDR_WIDTH, 6, AXI4-Lite byte-address width.
- C_S_AXI_DATA_WIDTH, 32, AXI4-Lite data width (fixed 32).
- N_POINTS, 8, DFT length (fixed 8; twiddle ROM sized for 8).

Ports:
- aclk  in  1  single clock (PS FCLK0)
- aresetn  in  1  asynchronous active-low reset
- s_axi_awaddr  in  6  write address
- s_axi_awvalid / s_axi_awready  in / out  1  write-address handshake
- s_axi_wdata  in  32  write data
- s_axi_wstrb  in  4  byte strobes (ignored; full-word writes only)
- s_axi_wvalid / s_axi_wready  in / out  1  write-data handshake
- s_axi_bresp  out  2  write response, always 2'b00
- s_axi_bvalid / s_axi_bready  out / in  1  write-response handshake
- s_axi_araddr  in  6  read address
- s_axi_arvalid / s_axi_arready  in / out  1  read-address handshake
- s_axi_rdata  out  32  read data
- s_axi_rresp  out  2  read response, always 2'b00
- s_axi_rvalid / s_axi_rready  out / in  1  read-data handshake
- led  out  4  led[0]=DONE, led[3:1]=PEAK_BIN

Behaviour:

Reset
- aresetn low clears every register, the sample buffer, the powers and all outputs to 0. All valid/ready signals are 0 and led=0.
- Reset mid-computation aborts it.

AXI write channel
- awready and wready pulse high together for one cycle when awvalid&wvalid are both high and bvalid=0.
- bvalid rises the next cycle and holds until bready.

AXI read channel
- arready pulses for one cycle when arvalid=1 and rvalid=0.
- rdata is registered; rvalid rises the next cycle and holds until rready.
- Unmapped reads return 0; unmapped writes are ignored. Responses are always OKAY.

Register map
- 0x00 CTRL (write-only, self-clearing, reads 0).
  - bit0 START: ignored while BUSY; otherwise clears DONE and starts the DFT.
  - bit1 CLEAR: aborts any computation to IDLE; zeroes the write pointer, SAMPLE_CNT, all POWER, PEAK_BIN and DONE. CLEAR wins if written together with START.
- 0x04 STATUS (read-only): bit0 BUSY, bit1 DONE (sticky), bits[6:4] PEAK_BIN.
- 0x08 SAMPLE_IN (write): wdata[15:0], signed, is stored at x[wptr], then wptr=(wptr+1) mod 8 (wraps and overwrites). Ignored while BUSY.
- 0x0C SAMPLE_CNT (read): samples written since CLEAR or reset, saturating at 8.
- 0x10+4k, k=0..7, POWER[k] (read-only).

DFT engine
- FSM: IDLE -> ACCUM (8 cycles, n=0..7, one MAC per cycle) -> POWER (1 cycle) -> ACCUM for the next bin, or DONE_ST after k=7 -> IDLE.
- BUSY=1 from the cycle after the START write until DONE sets: 72 cycles total.
- Twiddle index m=(k*n) mod 8, Q1.14.
  - cos[m] = 16384, 11585, 0, -11585, -16384, -11585, 0, 11585
  - sin[m] = 0, 11585, 16384, 11585, 0, -11585, -16384, -11585
- Accumulators are 36-bit signed: acc_re += x*cos, acc_im -= x*sin.
- In POWER: re = acc_re >>> 14 and im = acc_im >>> 14 (arithmetic). p = re*re + im*im, computed at 44 bits unsigned.
- POWER[k] = p if p < 2^32, else 0xFFFFFFFF.
- PEAK_BIN is a running maximum across bins; strict > compare, so ties keep the lowest index.
- SAMPLE_CNT < 8 does not block START; unwritten entries are 0.

Test Plan:
1. Reset, then read all registers -> all 0, led=4'b0000; during reset no valid/ready signals assert.
2. CLEAR, write x0=1000 and 7 zeros, START, poll STATUS.
   - BUSY for 72 cycles.
   - Every POWER[k]=0x000F4240.
   - PEAK_BIN=0, led=4'b0001.
3. CLEAR, 8 samples of 1000, START -> POWER[0]=0x03D09000 (64,000,000), POWER[1..7]=0, PEAK_BIN=0.
4. CLEAR, samples 1000,0,-1000,0,1000,0,-1000,0 (0xFC18 for -1000), START.
   - POWER[2]=POWER[6]=0x00F42400 (16,000,000), all other bins 0.
   - PEAK_BIN=2, led=4'b0101.
5. CLEAR, 8 samples of 32767, START -> POWER[0]=0xFFFFFFFF (saturated). While BUSY: a second START and SAMPLE_IN writes are ignored, and SAMPLE_CNT stays 8.
6. START, then CLEAR at cycle 20 -> BUSY=0 and DONE=0 next cycle, all POWER=0. Writing 9 samples -> SAMPLE_CNT=8 and x0 is overwritten by the 9th sample.
